// File: rtl/traffic_lights_cmd_parser.sv
// Byte-stream command parser for the traffic_lights controller: frames 5-byte packets
// (A5 OP DHI DLO CHK), validates them and issues one-cycle commands or counts rejections.
module traffic_lights_cmd_parser #(
  parameter int unsigned TIMEOUT_CYCLES = 200,
  parameter int unsigned MAX_TIME_MS    = 30000
) (
  input  logic        clk_2k_i,
  input  logic        arst_n_i,
  input  logic [7:0]  byte_data_i,
  input  logic        byte_valid_i,
  output logic        byte_ready_o,
  output logic [2:0]  cmd_type_o,
  output logic        cmd_valid_o,
  output logic [15:0] cmd_data_o,
  output logic        frame_err_o,
  output logic [7:0]  err_cnt_o
);

  localparam logic [7:0]  HEADER   = 8'hA5;
  localparam logic [7:0]  OP_MAX   = 8'h05;
  localparam logic [7:0]  OP_TIMED = 8'h03;  // ops at or above this carry a time in ms
  localparam logic [15:0] MAX_TIME = 16'(MAX_TIME_MS);
  localparam int          TW       = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_HUNT, S_OP, S_DHI, S_DLO, S_CHK, S_EMIT
  } state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [7:0]    op_q, dhi_q, dlo_q;
  logic          xfer;
  logic          frame_ok;
  logic          err_d;
  logic          emit_d;
  logic [15:0]   data;

  assign xfer = byte_valid_i && byte_ready_o;
  assign data = {dhi_q, dlo_q};

  always_comb begin
    frame_ok = (byte_data_i == (op_q ^ dhi_q ^ dlo_q)) && (op_q <= OP_MAX);
    if (op_q >= OP_TIMED) begin
      frame_ok = frame_ok && (data != 16'd0) && (data <= MAX_TIME);
    end else begin
      frame_ok = frame_ok && (data == 16'd0);
    end
  end

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latches).
    state_d = state_q;
    tcnt_d  = '0;
    err_d   = 1'b0;
    emit_d  = 1'b0;
    unique case (state_q)
      S_HUNT: if (xfer && byte_data_i == HEADER) state_d = S_OP;
      S_OP, S_DHI, S_DLO, S_CHK: begin
        if (xfer) begin
          unique case (state_q)
            S_OP:    state_d = S_DHI;
            S_DHI:   state_d = S_DLO;
            S_DLO:   state_d = S_CHK;
            default: begin
              state_d = frame_ok ? S_EMIT : S_HUNT;
              emit_d  = frame_ok;
              err_d   = !frame_ok;
            end
          endcase
        end else if (tcnt_q == T_LAST) begin
          state_d = S_HUNT;
          err_d   = 1'b1;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      S_EMIT:  state_d = S_HUNT;
      default: state_d = S_HUNT;
    endcase
  end

  always_ff @(posedge clk_2k_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q      <= S_HUNT;
      tcnt_q       <= '0;
      op_q         <= '0;
      dhi_q        <= '0;
      dlo_q        <= '0;
      byte_ready_o <= 1'b0;
      cmd_type_o   <= '0;
      cmd_valid_o  <= 1'b0;
      cmd_data_o   <= '0;
      frame_err_o  <= 1'b0;
      err_cnt_o    <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
      state_q      <= state_d;
      tcnt_q       <= tcnt_d;
      byte_ready_o <= (state_d != S_EMIT);
      cmd_valid_o  <= emit_d;
      frame_err_o  <= err_d;
      if (xfer && state_q == S_OP)  op_q  <= byte_data_i;
      if (xfer && state_q == S_DHI) dhi_q <= byte_data_i;
      if (xfer && state_q == S_DLO) dlo_q <= byte_data_i;
      if (emit_d) begin
        cmd_type_o <= op_q[2:0];
        cmd_data_o <= data;
      end
      if (err_d && err_cnt_o != 8'hFF) err_cnt_o <= err_cnt_o + 8'd1;
    end
  end

endmodule
